// File: rtl/hazard_unit_pkg.sv
// Shared pipeline-control types: hazard FSM states and operand-forwarding source selects.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERROR    = 2'd2
  } hazard_state_t;

  localparam logic [1:0] FWD_SRC_RF  = 2'd0;
  localparam logic [1:0] FWD_SRC_EX  = 2'd1;
  localparam logic [1:0] FWD_SRC_MEM = 2'd2;
  localparam logic [1:0] FWD_SRC_WB  = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear on rst.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline stall/flush controller: memory-wait freeze, taken-branch squash, load-use bubble,
// memory-timeout trap, plus saturating perf counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           id_sel_rs1_i,
  input  logic [4:0]           id_sel_rs2_i,
  input  logic                 id_uses_rs1_i,
  input  logic                 id_uses_rs2_i,
  input  logic [4:0]           ex_sel_rd_i,
  input  logic                 ex_is_load_i,
  input  logic                 ex_reg_write_i,
  input  logic                 ex_branch_taken_i,
  input  logic                 mem_req_i,
  input  logic                 mem_ready_i,
  output logic                 stall_if_o,
  output logic                 stall_id_o,
  output logic                 stall_ex_o,
  output logic                 stall_mem_o,
  output logic                 flush_id_o,
  output logic                 flush_ex_o,
  output logic                 flush_wb_o,
  output logic                 error_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o,
  output logic [CNT_WIDTH-1:0] flush_count_o
);

  // wait_cnt only needs to reach MEM_TIMEOUT-1 before the trap fires
  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  hazard_state_t     state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_wait, timeout, load_use;

  assign mem_wait = mem_req_i & ~mem_ready_i;
  assign timeout  = mem_wait && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
  assign load_use = ex_is_load_i & ex_reg_write_i & (ex_sel_rd_i != 5'd0) &
                    ((id_uses_rs1_i & (id_sel_rs1_i == ex_sel_rd_i)) |
                     (id_uses_rs2_i & (id_sel_rs2_i == ex_sel_rd_i)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !mem_wait) begin
      wait_cnt <= '0;
    end else if (state != S_ERROR) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RUN, S_MEM_WAIT: begin
        if (timeout) begin
          state_next = S_ERROR;
        end else if (mem_wait) begin
          state_next = S_MEM_WAIT;
        end else begin
          state_next = S_RUN;
        end
      end
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_RUN;
    endcase
  end

  // Priority: trap > memory wait > taken branch > load-use
  always_comb begin
    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    stall_ex_o  = 1'b0;
    stall_mem_o = 1'b0;
    flush_id_o  = 1'b0;
    flush_ex_o  = 1'b0;
    flush_wb_o  = 1'b0;
    if (!rst) begin
      if (state == S_ERROR) begin
        stall_if_o  = 1'b1;
        stall_id_o  = 1'b1;
        stall_ex_o  = 1'b1;
        stall_mem_o = 1'b1;
      end else if (mem_wait) begin
        stall_if_o  = 1'b1;
        stall_id_o  = 1'b1;
        stall_ex_o  = 1'b1;
        stall_mem_o = 1'b1;
        flush_wb_o  = 1'b1;
      end else if (ex_branch_taken_i) begin
        flush_id_o = 1'b1;
        flush_ex_o = 1'b1;
      end else if (load_use) begin
        stall_if_o = 1'b1;
        stall_id_o = 1'b1;
        flush_ex_o = 1'b1;
      end
    end
  end

  assign error_o = (state == S_ERROR);

  // flush_id_o is raised only by a taken branch, so it marks one flush event per cycle
  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall_if_o),
    .count (stall_cycles_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (flush_id_o),
    .count (flush_count_o)
  );

endmodule
